// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and constants for the clock-divider scheduler
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int DEFAULT_HALF_VAL = 1;
  localparam int PERIOD_CNT_W     = 16;

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - half-period counter, compare-and-toggle datapath for the divided clock
module clk_div_core #(
  parameter int HW           = 8,
  parameter int DEFAULT_HALF = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          clear,
  input  logic          load,
  input  logic [HW-1:0] load_half,
  output logic          clk_out,
  output logic          tick,
  output logic          boundary,
  output logic          at_start
);

  logic [HW-1:0] cnt;
  logic [HW-1:0] half;
  logic          at_end;

  // Equality compare before increment keeps cnt <= half, so half = all-ones never wraps.
  assign at_end   = (cnt == half);
  assign boundary = at_end && clk_out;
  assign at_start = (cnt == '0) && !clk_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      half    <= HW'(DEFAULT_HALF);
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (load) begin
        half <= load_half;
      end
      if (clear) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (run) begin
        if (at_end) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= ~clk_out;
        end else begin
          cnt  <= cnt + HW'(1);
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_sched.sv
// rtl/clk_div_sched.sv - divider FSM with boundary-aligned ratio updates; CLK_DIV_SCHED_STATUS_EN adds period_cnt
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter int HW           = 8,
  parameter int DEFAULT_HALF = DEFAULT_HALF_VAL
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          cfg_valid,
  input  logic [HW-1:0] cfg_half,
  output logic          cfg_ready,
  output logic          clk_out,
  output logic          tick,
  output logic          busy
`ifdef CLK_DIV_SCHED_STATUS_EN
  ,
  output logic [PERIOD_CNT_W-1:0] period_cnt
`endif
);

  state_t        state, next_state;
  logic          pend;
  logic [HW-1:0] pend_half;
  logic          xfer;
  logic          run, clear, load, apply_pt;
  logic [HW-1:0] load_half;
  logic          boundary, at_start;

  assign cfg_ready = !pend;
  assign xfer      = cfg_valid && cfg_ready;
  assign busy      = (state != IDLE);

  clk_div_core #(
    .HW           (HW),
    .DEFAULT_HALF (DEFAULT_HALF)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .clear     (clear),
    .load      (load),
    .load_half (load_half),
    .clk_out   (clk_out),
    .tick      (tick),
    .boundary  (boundary),
    .at_start  (at_start)
  );

  always_comb begin
    next_state = state;
    run        = 1'b0;
    clear      = 1'b0;
    load       = 1'b0;
    load_half  = cfg_half;
    case (state)
      IDLE: begin
        clear = 1'b1;
        load  = xfer;
        if (enable) next_state = RUN;
      end
      RUN: begin
        // Stopping before any part of a period has been produced needs no drain.
        if (!enable && at_start) begin
          next_state = IDLE;
        end else begin
          run = 1'b1;
          if (!enable) next_state = STOP;
        end
      end
      STOP: begin
        if (enable) begin
          next_state = RUN;
          run        = 1'b1;
        end else if (at_start) begin
          next_state = IDLE;
        end else begin
          run = 1'b1;
          if (boundary) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    // A pending ratio lands only where a new period would begin.
    apply_pt = (run && boundary) || (state != IDLE && next_state == IDLE);
    if (apply_pt && pend) begin
      load      = 1'b1;
      load_half = pend_half;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pend      <= 1'b0;
      pend_half <= '0;
    end else begin
      state <= next_state;
      if (xfer && state != IDLE) begin
        pend      <= 1'b1;
        pend_half <= cfg_half;
      end else if (apply_pt && pend) begin
        pend <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_SCHED_STATUS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
    end else if (state == STOP && next_state == IDLE) begin
      period_cnt <= '0;
    end else if (run && boundary && !(&period_cnt)) begin
      period_cnt <= period_cnt + PERIOD_CNT_W'(1);
    end
  end
`endif

endmodule
